// File: rtl/status_led_ctrl_pkg.sv
// Shared constants for the status LED controller: colours, channel modes and
// per-channel FSM state encodings.
package status_led_ctrl_pkg;

  // Colours are {R,G,B}
  localparam logic [2:0] COL_OFF  = 3'b000;
  localparam logic [2:0] COL_IDLE = 3'b100;
  localparam logic [2:0] COL_WR   = 3'b001;
  localparam logic [2:0] COL_INT  = 3'b011;
  localparam logic [2:0] COL_RST  = 3'b110;

  localparam logic [1:0] MODE_EVENT = 2'b00;
  localparam logic [1:0] MODE_OFF   = 2'b01;
  localparam logic [1:0] MODE_FORCE = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_SHOW  = 2'd1;
  localparam logic [1:0] ST_INT_SHOW = 2'd2;

  // Event colour shown for a given channel FSM state
  function automatic logic [2:0] state_colour(input logic [1:0] st);
    case (st)
      ST_WR_SHOW:  state_colour = COL_WR;
      ST_INT_SHOW: state_colour = COL_INT;
      default:     state_colour = COL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/status_led_ctrl_channel.sv
// One RGB channel: event FSM with pulse stretcher, config registers,
// mode-dependent colour select and PWM brightness gating.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | no recent event, idle colour
// ST_WR_SHOW  | write event seen within the last STRETCH_CYCLES cycles
// ST_INT_SHOW | interrupt seen within the last STRETCH_CYCLES cycles;
//             | write strobes are ignored here and do not reload
module status_led_ctrl_channel
  import status_led_ctrl_pkg::*;
#(
  parameter int PWM_BITS       = 8,
  parameter int STRETCH_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_int_evt,
  input  logic                  i_wr_evt,
  input  logic                  i_cfg_we,
  input  logic [PWM_BITS+4:0]   i_cfg_wdata,
  input  logic [PWM_BITS-1:0]   i_pwm_cnt,
  input  logic                  i_blink_phase,
  output logic [2:0]            o_colour
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PWM_BITS-1:0] r_bright;
  logic [1:0]          r_mode;
  logic [2:0]          r_colour;

  logic [2:0] w_base;
  logic [2:0] w_sel;
  logic       w_pwm_en;

  // Event FSM and stretch counter; interrupts win over writes and always reload
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_int_evt) begin
      r_state <= ST_INT_SHOW;
      r_cnt   <= CNT_LOAD;
    end else if (i_wr_evt && (r_state != ST_INT_SHOW)) begin
      r_state <= ST_WR_SHOW;
      r_cnt   <= CNT_LOAD;
    end else if (r_cnt == CNT_ONE) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  // Config registers, written from the decoded channel strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bright <= '1;
      r_mode   <= MODE_EVENT;
      r_colour <= COL_OFF;
    end else if (i_cfg_we) begin
      r_colour <= i_cfg_wdata[PWM_BITS+4:PWM_BITS+2];
      r_mode   <= i_cfg_wdata[PWM_BITS+1:PWM_BITS];
      r_bright <= i_cfg_wdata[PWM_BITS-1:0];
    end
  end

  // Colour select by mode, then PWM gating; full-scale brightness never dims
  always_comb begin
    w_base = state_colour(r_state);
    w_sel  = COL_OFF;
    case (r_mode)
      MODE_EVENT: w_sel = w_base;
      MODE_OFF:   w_sel = COL_OFF;
      MODE_FORCE: w_sel = r_colour;
      MODE_BLINK: w_sel = ((r_state == ST_INT_SHOW) && !i_blink_phase) ? COL_OFF : w_base;
      default:    w_sel = COL_OFF;
    endcase
    w_pwm_en = (r_bright == {PWM_BITS{1'b1}}) || (i_pwm_cnt < r_bright);
    o_colour = w_pwm_en ? w_sel : COL_OFF;
  end

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel RGB status indicator. Holds the shared PWM and blink
// timebases, the post-reset hold timer, config channel decode and the
// registered LED outputs.
module status_led_ctrl
  import status_led_ctrl_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int PWM_BITS       = 8,
  parameter int STRETCH_CYCLES = 1000,
  parameter int BLINK_DIV      = 500000,
  parameter int RESET_HOLD     = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_CH-1:0]     i_int_evt,
  input  logic [NUM_CH-1:0]     i_wr_evt,
  input  logic                  i_cfg_we,
  input  logic [2:0]            i_cfg_sel,
  input  logic [PWM_BITS+4:0]   i_cfg_wdata,
  output logic [3*NUM_CH-1:0]   o_lights
);

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam int HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;
  logic [HOLD_W-1:0]   r_hold;
  logic [3*NUM_CH-1:0] r_lights;

  logic [NUM_CH-1:0]   w_cfg_we;
  logic [3*NUM_CH-1:0] w_colour;

  // Free-running PWM timebase shared by all channels
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pwm_cnt <= '0;
    else         r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Blink divider; phase flips each time the divider wraps
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Reset-hold down-counter; the reset edge itself shows the first hold cycle
  always_ff @(posedge i_clk) begin
    if (i_reset)             r_hold <= HOLD_LOAD;
    else if (r_hold != '0)   r_hold <= r_hold - HOLD_ONE;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Selects outside 0..NUM_CH-1 match no channel and are dropped
    assign w_cfg_we[g] = i_cfg_we && (i_cfg_sel == 3'(g));

    status_led_ctrl_channel #(
      .PWM_BITS       (PWM_BITS),
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_ch (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_int_evt     (i_int_evt[g]),
      .i_wr_evt      (i_wr_evt[g]),
      .i_cfg_we      (w_cfg_we[g]),
      .i_cfg_wdata   (i_cfg_wdata),
      .i_pwm_cnt     (r_pwm_cnt),
      .i_blink_phase (r_blink_phase),
      .o_colour      (w_colour[3*g +: 3])
    );
  end

  // Output register: reset colour during hold, channel colours afterwards
  always_ff @(posedge i_clk) begin
    if (i_reset)               r_lights <= {NUM_CH{COL_RST}};
    else if (r_hold > HOLD_ONE) r_lights <= {NUM_CH{COL_RST}};
    else                       r_lights <= w_colour;
  end

  assign o_lights = r_lights;

endmodule

// File: tb/tb_status_led_ctrl.sv
module tb_status_led_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  int_evt;
  logic [1:0]  wr_evt;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [12:0] cfg_wdata;
  logic [5:0]  lights;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rst_edge = 0;

  typedef struct {
    int         cyc;
    logic [5:0] expv;
    logic [5:0] mask;
    bit [63:0]  nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  status_led_ctrl #(
    .NUM_CH         (2),
    .PWM_BITS       (8),
    .STRETCH_CYCLES (3),
    .BLINK_DIV      (4),
    .RESET_HOLD     (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_int_evt   (int_evt),
    .i_wr_evt    (wr_evt),
    .i_cfg_we    (cfg_we),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_wdata (cfg_wdata),
    .o_lights    (lights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input bit [63:0] nm, input logic [5:0] act,
                           input logic [5:0] expv, input logic [5:0] mask);
    n_checks++;
    if ((act & mask) !== (expv & mask)) begin
      n_fail++;
      $display("FAIL %s cycle %0d: lights=%b expected=%b mask=%b", nm, cyc, act, expv, mask);
    end
  endtask

  task automatic check_int(input bit [63:0] nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input int k, input logic [5:0] expv, input logic [5:0] mask,
                      input bit [63:0] nm);
    exp_t t;
    t.cyc  = k;
    t.expv = expv;
    t.mask = mask;
    t.nm   = nm;
    sb_q.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: pops every expectation due at this output edge
  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mon_e.nm, mon_e.cyc, cyc);
      end else begin
        check_vec(mon_e.nm, lights, mon_e.expv, mon_e.mask);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n_on, n_off, n_ch0, ph;
    reset = 1'b1; int_evt = '0; wr_evt = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;

    // Reset and hold: 110 per channel for four outputs, then idle
    c = cyc;
    for (int k = 1; k <= 4; k++) push(c + k, 6'b110110, 6'h3F, "rst_hold");
    push(c + 5, 6'b100100, 6'h3F, "rst_end");
    push(c + 6, 6'b100100, 6'h3F, "rst_end");
    tick(1); reset = 1'b0; tick(6);

    // Single write pulse on channel 0
    c = cyc;
    wr_evt = 2'b01;
    for (int k = 2; k <= 4; k++) push(c + k, 6'b100001, 6'h3F, "wr_pulse");
    push(c + 5, 6'b100100, 6'h3F, "wr_end");
    tick(1); wr_evt = 2'b00; tick(6);

    // int+wr together, then wr during INT_SHOW must not reload
    c = cyc;
    int_evt = 2'b01; wr_evt = 2'b01;
    for (int k = 2; k <= 4; k++) push(c + k, 6'b100011, 6'h3F, "int_wr");
    push(c + 5, 6'b100100, 6'h3F, "int_end");
    tick(1); int_evt = 2'b00;
    tick(1); wr_evt = 2'b00;
    tick(5);

    // Interrupt retriggered on the expiry edge extends by a full stretch
    c = cyc;
    int_evt = 2'b01;
    for (int k = 2; k <= 7; k++) push(c + k, 6'b100011, 6'h3F, "retrig");
    push(c + 8, 6'b100100, 6'h3F, "retr_end");
    tick(1); int_evt = 2'b00;
    tick(2); int_evt = 2'b01;
    tick(1); int_evt = 2'b00;
    tick(6);

    // Reset in the middle of INT_SHOW
    c = cyc;
    int_evt = 2'b01;
    push(c + 2, 6'b100011, 6'h3F, "pre_rst");
    for (int k = 3; k <= 6; k++) push(c + k, 6'b110110, 6'h3F, "rst_mid");
    push(c + 7, 6'b100100, 6'h3F, "rst_rel");
    tick(1); int_evt = 2'b00;
    tick(1); reset = 1'b1; rst_edge = c + 3;
    tick(1); reset = 1'b0;
    tick(6);

    // Channel 1 brightness 0x40: on for exactly 64 of 256 cycles
    c = cyc;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_wdata = 13'h0040;
    tick(1); cfg_we = 1'b0;
    tick(1);
    n_on = 0; n_off = 0; n_ch0 = 0;
    repeat (256) begin
      @(negedge clk);
      if (lights[5:3] == 3'b100) n_on++;
      else if (lights[5:3] == 3'b000) n_off++;
      if (lights[2:0] == 3'b100) n_ch0++;
    end
    check_int("pwm_on", n_on, 64);
    check_int("pwm_off", n_off, 192);
    check_int("ch0_pwm", n_ch0, 256);
    @(posedge clk); #1;

    // Brightness zero: channel 1 dark for a full PWM period
    c = cyc;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_wdata = 13'h0000;
    for (int k = 2; k <= 257; k++) push(c + k, 6'b000100, 6'h3F, "bright0");
    tick(1); cfg_we = 1'b0;
    tick(258);

    // Blink mode, interrupt held: 011 in phase 1, off in phase 0
    c = cyc;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_wdata = 13'h03FF;
    int_evt = 2'b10;
    for (int m = c + 2; m <= c + 17; m++) begin
      ph = ((m - 1 - rst_edge) / 4) % 2;
      push(m, (ph == 1) ? 6'b011100 : 6'b000100, 6'h3F, "blink");
    end
    tick(1); cfg_we = 1'b0;
    tick(17); int_evt = 2'b00;

    // Forced colour 010, then a write to sel=5 must change nothing
    c = cyc;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_wdata = 13'h0AFF;
    push(c + 2, 6'b010100, 6'h3F, "force");
    push(c + 3, 6'b010100, 6'h3F, "force");
    for (int k = 4; k <= 9; k++) push(c + k, 6'b010100, 6'h3F, "sel5");
    tick(1); cfg_we = 1'b0;
    tick(1); cfg_we = 1'b1; cfg_sel = 3'd5; cfg_wdata = 13'h01FF;
    tick(1); cfg_we = 1'b0;
    tick(8);

    // Channel 0 forced off while its FSM keeps running
    c = cyc;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_wdata = 13'h01FF;
    wr_evt = 2'b01;
    push(c + 2, 6'b010000, 6'h3F, "off_mode");
    push(c + 3, 6'b010001, 6'h3F, "off_fsm");
    push(c + 4, 6'b010001, 6'h3F, "off_fsm");
    push(c + 5, 6'b010100, 6'h3F, "off_end");
    tick(1); cfg_wdata = 13'h00FF; wr_evt = 2'b00;
    tick(1); cfg_we = 1'b0;
    tick(5);

    check_int("sb_left", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
